// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Writer side of the six-lane 48-bit instruction store. Bytes arriving from the
// UART receive path are packed six at a time into one instruction word, which
// is then written into the six byte-wide program RAM chips at an
// auto-incrementing address using a timed active-low write strobe. While a
// session is active the loader owns the program-store address/data lanes.
//
// Parameters
//   WE_CYCLES  clocks _rom_we is held low per word write (1..15)
//   LOG        word logging hook for simulation environments (no RTL effect)
//
// Ports
//   clk         in   1   system clock, rising edge
//   _mr         in   1   master reset, asynchronous, active-low
//   load_en     in   1   request / continue a load session
//   start_addr  in  16   first word address, captured at session start
//   rx_data     in   8   incoming program byte
//   rx_valid    in   1   rx_data holds a byte
//   rx_ready    out  1   loader accepts a byte (transfer = rx_valid & rx_ready)
//   rom_addr    out 16   program-store address
//   rom_data    out 48   assembled word, byte k in bits [8k-1:8k-8]
//   _rom_we     out  1   write strobe for all six chips, active-low
//   _loading    out  1   low while a session is active (address mux select)
//   word_count  out 16   words committed this session
//   checksum    out  8   mod-256 sum of accepted bytes this session
//   _partial    out  1   sticky low: session ended with an incomplete word
//   _wrapped    out  1   sticky low: address wrapped 0xFFFF -> 0x0000
// -----------------------------------------------------------------------------
module program_loader #(
   parameter int WE_CYCLES = 2,
   parameter int LOG       = 0
) (
   input  logic        clk,
   input  logic        _mr,
   input  logic        load_en,
   input  logic [15:0] start_addr,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [15:0] rom_addr,
   output logic [47:0] rom_data,
   output logic        _rom_we,
   output logic        _loading,
   output logic [15:0] word_count,
   output logic [7:0]  checksum,
   output logic        _partial,
   output logic        _wrapped
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      SETUP   = 3'd2,
      WRITE   = 3'd3,
      HOLD    = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  byte_idx, byte_idx_nxt;
   logic [3:0]  we_cnt, we_cnt_nxt;
   logic [15:0] rom_addr_nxt;
   logic [47:0] rom_data_nxt;
   logic [15:0] word_count_nxt;
   logic [7:0]  checksum_nxt;
   logic        partial_nxt;
   logic        wrapped_nxt;
   logic        rx_ready_nxt;
   logic        loading_nxt;
   logic        rom_we_nxt;
   logic        transfer;

   // rx_ready is a flop, so the handshake never depends combinationally on
   // rx_valid.
   assign transfer = rx_valid & rx_ready;

   // Word logging is left to the simulation environment; nothing is built here.
   if (LOG != 0) begin : g_log
   end

   // Next-state and next-value logic
   always_comb begin
      state_nxt      = state;
      byte_idx_nxt   = byte_idx;
      we_cnt_nxt     = we_cnt;
      rom_addr_nxt   = rom_addr;
      rom_data_nxt   = rom_data;
      word_count_nxt = word_count;
      checksum_nxt   = checksum;
      partial_nxt    = _partial;
      wrapped_nxt    = _wrapped;

      case (state)
         IDLE: begin
            if (load_en) begin
               rom_addr_nxt   = start_addr;
               word_count_nxt = '0;
               checksum_nxt   = '0;
               byte_idx_nxt   = '0;
               partial_nxt    = 1'b1;
               wrapped_nxt    = 1'b1;
               state_nxt      = COLLECT;
            end
         end

         COLLECT: begin
            if (transfer) begin
               // A byte arriving on the same edge load_en drops is still taken;
               // the session end is re-evaluated on the following edge.
               for (int k = 0; k < 6; k++) begin
                  if (byte_idx == 3'(k)) rom_data_nxt[8*k +: 8] = rx_data;
               end
               checksum_nxt = checksum + rx_data;
               if (byte_idx == 3'd5) begin
                  byte_idx_nxt = '0;
                  state_nxt    = SETUP;
               end else begin
                  byte_idx_nxt = byte_idx + 3'd1;
               end
            end else if (!load_en) begin
               // An incomplete word is dropped, never written.
               if (byte_idx != 3'd0) partial_nxt = 1'b0;
               byte_idx_nxt = '0;
               state_nxt    = IDLE;
            end
         end

         SETUP: begin
            we_cnt_nxt = 4'(WE_CYCLES - 1);
            state_nxt  = WRITE;
         end

         WRITE: begin
            if (we_cnt == 4'd0) state_nxt = HOLD;
            else                we_cnt_nxt = we_cnt - 4'd1;
         end

         HOLD: begin
            word_count_nxt = word_count + 16'd1;
            rom_addr_nxt   = rom_addr + 16'd1;
            if (rom_addr == 16'hFFFF) wrapped_nxt = 1'b0;
            state_nxt = load_en ? COLLECT : IDLE;
         end

         default: state_nxt = IDLE;
      endcase

      // Strobes are decoded from the next state and registered, so the RAM
      // write enable and address mux select are glitch-free flop outputs.
      rx_ready_nxt = (state_nxt == COLLECT);
      loading_nxt  = (state_nxt == IDLE);
      rom_we_nxt   = (state_nxt != WRITE);
   end

   // State register; asynchronous reset also lifts _rom_we mid-write
   always_ff @(posedge clk or negedge _mr) begin
      if (!_mr) begin
         state      <= IDLE;
         byte_idx   <= '0;
         we_cnt     <= '0;
         rom_addr   <= '0;
         rom_data   <= '0;
         word_count <= '0;
         checksum   <= '0;
         _partial   <= 1'b1;
         _wrapped   <= 1'b1;
         rx_ready   <= 1'b0;
         _loading   <= 1'b1;
         _rom_we    <= 1'b1;
      end else begin
         state      <= state_nxt;
         byte_idx   <= byte_idx_nxt;
         we_cnt     <= we_cnt_nxt;
         rom_addr   <= rom_addr_nxt;
         rom_data   <= rom_data_nxt;
         word_count <= word_count_nxt;
         checksum   <= checksum_nxt;
         _partial   <= partial_nxt;
         _wrapped   <= wrapped_nxt;
         rx_ready   <= rx_ready_nxt;
         _loading   <= loading_nxt;
         _rom_we    <= rom_we_nxt;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed bench for program_loader. Instance a uses WE_CYCLES=2, instance b
// uses WE_CYCLES=3; both share the stimulus and each scenario checks the
// instance it targets. Inputs change 1 time unit after the rising edge and
// outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_program_loader;

   logic        clk = 1'b0;
   logic        mr_n;
   logic        load_en;
   logic [15:0] start_addr;
   logic [7:0]  rx_data;
   logic        rx_valid;

   logic        a_rx_ready, a_rom_we_n, a_loading_n, a_partial_n, a_wrapped_n;
   logic [15:0] a_rom_addr, a_word_count;
   logic [47:0] a_rom_data;
   logic [7:0]  a_checksum;

   logic        b_rx_ready, b_rom_we_n, b_loading_n, b_partial_n, b_wrapped_n;
   logic [15:0] b_rom_addr, b_word_count;
   logic [47:0] b_rom_data;
   logic [7:0]  b_checksum;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   program_loader #(.WE_CYCLES(2), .LOG(0)) dut_a (
      .clk(clk), ._mr(mr_n), .load_en(load_en), .start_addr(start_addr),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(a_rx_ready),
      .rom_addr(a_rom_addr), .rom_data(a_rom_data), ._rom_we(a_rom_we_n),
      ._loading(a_loading_n), .word_count(a_word_count), .checksum(a_checksum),
      ._partial(a_partial_n), ._wrapped(a_wrapped_n)
   );

   program_loader #(.WE_CYCLES(3), .LOG(0)) dut_b (
      .clk(clk), ._mr(mr_n), .load_en(load_en), .start_addr(start_addr),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(b_rx_ready),
      .rom_addr(b_rom_addr), .rom_data(b_rom_data), ._rom_we(b_rom_we_n),
      ._loading(b_loading_n), .word_count(b_word_count), .checksum(b_checksum),
      ._partial(b_partial_n), ._wrapped(b_wrapped_n)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic rdy(input bit use_b);
      return use_b ? b_rx_ready : a_rx_ready;
   endfunction

   function automatic logic we_n(input bit use_b);
      return use_b ? b_rom_we_n : a_rom_we_n;
   endfunction

   task automatic do_reset();
      mr_n       = 1'b0;
      load_en    = 1'b0;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;
      start_addr = 16'h0000;
      tick();
      tick();
      mr_n = 1'b1;
      tick();
   endtask

   // Wait (bounded) for rx_ready; returns the number of cycles it was low.
   task automatic wait_ready(input bit use_b, output int low);
      low = 0;
      while (!rdy(use_b) && low < 100) begin
         tick();
         low++;
      end
      if (low >= 100) chk("ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_byte(input bit use_b, input logic [7:0] b);
      int low;
      rx_data  = b;
      rx_valid = 1'b1;
      wait_ready(use_b, low);
      tick();
      rx_valid = 1'b0;
   endtask

   // Called in SETUP right after the sixth byte: counts rx_ready-low cycles and
   // write-strobe-low cycles, capturing address/data while the strobe is low.
   task automatic finish_word(input bit use_b, output int rdy_low, output int we_low,
                              output logic [15:0] waddr, output logic [47:0] wdata);
      rdy_low = 0;
      we_low  = 0;
      waddr   = 16'h0000;
      wdata   = 48'h0;
      while (!rdy(use_b) && rdy_low < 100) begin
         if (!we_n(use_b)) begin
            we_low++;
            waddr = use_b ? b_rom_addr : a_rom_addr;
            wdata = use_b ? b_rom_data : a_rom_data;
         end
         rdy_low++;
         tick();
      end
      if (rdy_low >= 100) chk("word_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int          rl, wl, n;
      logic [15:0] wa;
      logic [47:0] wd;

      // ---------------- reset state ----------------
      do_reset();
      mr_n = 1'b0;
      tick();
      chk("rst_rom_addr", a_rom_addr, 16'h0000);
      chk("rst_rom_data", a_rom_data, 48'h0);
      chk("rst_rom_we", a_rom_we_n, 1'b1);
      chk("rst_rx_ready", a_rx_ready, 1'b0);
      chk("rst_loading", a_loading_n, 1'b1);
      chk("rst_word_count", a_word_count, 16'h0);
      chk("rst_checksum", a_checksum, 8'h0);
      chk("rst_partial", a_partial_n, 1'b1);
      chk("rst_wrapped", a_wrapped_n, 1'b1);
      mr_n = 1'b1;
      tick();

      // ---------------- one word at 0x0100 ----------------
      start_addr = 16'h0100;
      load_en    = 1'b1;
      tick();
      chk("s1_loading", a_loading_n, 1'b0);
      chk("s1_rx_ready", a_rx_ready, 1'b1);
      chk("s1_start_addr", a_rom_addr, 16'h0100);
      for (int i = 1; i <= 6; i++) send_byte(1'b0, 8'(i));
      chk("s1_setup_we", a_rom_we_n, 1'b1);
      chk("s1_setup_ready", a_rx_ready, 1'b0);
      finish_word(1'b0, rl, wl, wa, wd);
      chk("s1_we_cycles", 64'(wl), 64'd2);
      chk("s1_ready_low", 64'(rl), 64'd4);
      chk("s1_waddr", wa, 16'h0100);
      chk("s1_wdata", wd, 48'h060504030201);
      chk("s1_word_count", a_word_count, 16'd1);
      chk("s1_checksum", a_checksum, 8'h15);
      chk("s1_next_addr", a_rom_addr, 16'h0101);
      chk("s1_data_kept", a_rom_data, 48'h060504030201);

      // ---------------- back-to-back, WE_CYCLES=3, rx_valid held ----------------
      do_reset();
      start_addr = 16'h0000;
      load_en    = 1'b1;
      tick();
      rx_valid = 1'b1;
      for (int w = 0; w < 2; w++) begin
         for (int j = 0; j < 6; j++) begin
            rx_data = 8'(8'h10 + 6 * w + j);
            chk("s2_ready_before_byte", b_rx_ready, 1'b1);
            tick();
         end
         finish_word(1'b1, rl, wl, wa, wd);
         chk("s2_ready_low", 64'(rl), 64'd5);
         chk("s2_we_cycles", 64'(wl), 64'd3);
         chk("s2_waddr", wa, 16'(w));
         chk("s2_wdata", wd, (w == 0) ? 48'h151413121110 : 48'h1B1A19181716);
      end
      rx_valid = 1'b0;
      chk("s2_word_count", b_word_count, 16'd2);
      chk("s2_checksum", b_checksum, 8'h02);

      // ---------------- address wrap ----------------
      do_reset();
      start_addr = 16'hFFFF;
      load_en    = 1'b1;
      tick();
      for (int i = 1; i <= 6; i++) send_byte(1'b0, 8'(i));
      finish_word(1'b0, rl, wl, wa, wd);
      chk("s3_waddr0", wa, 16'hFFFF);
      chk("s3_wrapped", a_wrapped_n, 1'b0);
      chk("s3_addr_after_wrap", a_rom_addr, 16'h0000);
      for (int i = 7; i <= 12; i++) send_byte(1'b0, 8'(i));
      finish_word(1'b0, rl, wl, wa, wd);
      chk("s3_waddr1", wa, 16'h0000);
      chk("s3_final_addr", a_rom_addr, 16'h0001);
      chk("s3_word_count", a_word_count, 16'd2);
      chk("s3_checksum", a_checksum, 8'h4E);
      chk("s3_wrapped_sticky", a_wrapped_n, 1'b0);

      // ---------------- abort with partial word ----------------
      do_reset();
      start_addr = 16'h0200;
      load_en    = 1'b1;
      tick();
      send_byte(1'b0, 8'hAA);
      send_byte(1'b0, 8'hBB);
      send_byte(1'b0, 8'hCC);
      load_en = 1'b0;
      tick();
      chk("s4_partial", a_partial_n, 1'b0);
      chk("s4_loading", a_loading_n, 1'b1);
      chk("s4_rx_ready", a_rx_ready, 1'b0);
      chk("s4_word_count", a_word_count, 16'd0);
      chk("s4_checksum", a_checksum, 8'h31);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (!a_rom_we_n) n++;
         tick();
      end
      chk("s4_no_we_pulse", 64'(n), 64'd0);
      load_en = 1'b1;
      tick();
      chk("s4_new_partial", a_partial_n, 1'b1);
      chk("s4_new_checksum", a_checksum, 8'h00);
      chk("s4_new_addr", a_rom_addr, 16'h0200);

      // ---------------- load_en dropped during WRITE ----------------
      for (int i = 1; i <= 6; i++) send_byte(1'b0, 8'(8'h20 + i));
      tick();
      chk("s5_in_write", a_rom_we_n, 1'b0);
      load_en = 1'b0;
      n = 1;
      tick();
      while (!a_rom_we_n && n < 40) begin
         n++;
         tick();
      end
      chk("s5_we_cycles", 64'(n), 64'd2);
      tick();
      chk("s5_word_count", a_word_count, 16'd1);
      chk("s5_loading", a_loading_n, 1'b1);
      chk("s5_rx_ready", a_rx_ready, 1'b0);
      chk("s5_addr", a_rom_addr, 16'h0201);

      // ---------------- asynchronous reset mid-WRITE ----------------
      do_reset();
      start_addr = 16'h0300;
      load_en    = 1'b1;
      tick();
      for (int i = 1; i <= 6; i++) send_byte(1'b0, 8'(8'h30 + i));
      tick();
      chk("s6_in_write", a_rom_we_n, 1'b0);
      #2;
      mr_n = 1'b0;
      #1;
      chk("s6_we_async", a_rom_we_n, 1'b1);
      chk("s6_rx_ready", a_rx_ready, 1'b0);
      chk("s6_loading", a_loading_n, 1'b1);
      chk("s6_rom_addr", a_rom_addr, 16'h0000);
      chk("s6_rom_data", a_rom_data, 48'h0);
      chk("s6_word_count", a_word_count, 16'h0);
      chk("s6_checksum", a_checksum, 8'h0);
      chk("s6_b_we", b_rom_we_n, 1'b1);
      load_en = 1'b0;
      tick();
      mr_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
